// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode/state encodings and bus request codes for the
// sequential accumulator ALU.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADDI = 4'h1,
        OP_SUBI = 4'h2,
        OP_ANDI = 4'h3,
        OP_ORI  = 4'h4,
        OP_XORI = 4'h5,
        OP_LDI  = 4'h6,
        OP_ILL  = 4'h7,
        OP_ADD  = 4'h8,
        OP_SUB  = 4'h9,
        OP_AND  = 4'hA,
        OP_OR   = 4'hB,
        OP_XOR  = 4'hC,
        OP_LDR  = 4'hD,
        OP_SHL  = 4'hE,
        OP_SHR  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSRD = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [3:0] REQ_IDLE = 4'b0000;
    localparam logic [3:0] REQ_READ = 4'b0001;

    // Register-form ops fetch their operand over the bus first.
    function automatic logic is_reg_op(input logic [3:0] opc);
        return (opc >= OP_ADD) && (opc <= OP_LDR);
    endfunction

    // The illegal opcode behaves exactly like NOP.
    function automatic logic is_nop_op(input logic [3:0] opc);
        return (opc == OP_NOP) || (opc == OP_ILL);
    endfunction

endpackage

// File: rtl/alu_seq_datapath.sv
// alu_seq_datapath: combinational op/flag unit. Produces the next accumulator,
// carry/borrow and zero for the latched opcode; NOP/illegal pass acc and carry.
module alu_seq_datapath
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        opc,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] opnd,
    input  logic              carry_in,
    output logic [DATA_W-1:0] acc_nxt,
    output logic              carry_nxt,
    output logic              zero_nxt
);

    logic [DATA_W:0] sum;

    // Opcode decode: add/sub expose bit DATA_W as carry/borrow, other ops clear carry.
    always_comb begin
        acc_nxt   = acc;
        carry_nxt = carry_in;
        sum       = '0;
        case (opc)
            OP_ADDI, OP_ADD: begin
                sum       = {1'b0, acc} + {1'b0, opnd};
                acc_nxt   = sum[DATA_W-1:0];
                carry_nxt = sum[DATA_W];
            end
            OP_SUBI, OP_SUB: begin
                sum       = {1'b0, acc} - {1'b0, opnd};
                acc_nxt   = sum[DATA_W-1:0];
                carry_nxt = sum[DATA_W];
            end
            OP_ANDI, OP_AND: begin
                acc_nxt   = acc & opnd;
                carry_nxt = 1'b0;
            end
            OP_ORI, OP_OR: begin
                acc_nxt   = acc | opnd;
                carry_nxt = 1'b0;
            end
            OP_XORI, OP_XOR: begin
                acc_nxt   = acc ^ opnd;
                carry_nxt = 1'b0;
            end
            OP_LDI, OP_LDR: begin
                acc_nxt   = opnd;
                carry_nxt = 1'b0;
            end
            OP_SHL: begin
                acc_nxt   = acc << opnd[2:0];
                carry_nxt = 1'b0;
            end
            OP_SHR: begin
                acc_nxt   = acc >> opnd[2:0];
                carry_nxt = 1'b0;
            end
            default: begin
                acc_nxt   = acc;
                carry_nxt = carry_in;
            end
        endcase
    end

    assign zero_nxt = (acc_nxt == '0);

endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential accumulator ALU with a valid/ready instruction
// handshake and a bus-read handshake for register-form operands.
// Build option BUS_TIMEOUT_EN: a down-counter bounds the wait for bus_ack to
// TIMEOUT_CYC enabled cycles; on expiry the op ends in DONE with err=1 and
// acc/flags untouched. Without it BUSRD waits forever and err is 0.
//
// state | meaning
// IDLE  | instr_ready high, waiting for an instruction
// BUSRD | bus_req=REQ_READ on bus_addr, waiting for bus_ack
// EXEC  | acc and flags updated from the latched op
// DONE  | done strobe for one enabled cycle
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int OPND_W      = 4,
    parameter int OPC_W       = 4,
    parameter int BUSREQ_W    = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [OPND_W+OPC_W-1:0] instr_in,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    output logic [BUSREQ_W-1:0]     bus_req,
    output logic [OPND_W-1:0]       bus_addr,
    input  logic                    bus_ack,
    input  logic [DATA_W-1:0]       bus_rdata,
    output logic [DATA_W-1:0]       acc,
    output logic                    carry,
    output logic                    zero,
    output logic                    done,
    output logic                    err
);

    if (DATA_W < 4) begin : g_chk_data_w
        $error("alu_seq_core: DATA_W must be at least 4");
    end
    if (OPC_W != 4) begin : g_chk_opc_w
        $error("alu_seq_core: opcode encoding needs OPC_W == 4");
    end
    if (TIMEOUT_CYC < 1) begin : g_chk_timeout
        $error("alu_seq_core: TIMEOUT_CYC must be at least 1");
    end

    state_e                state_q, state_d;
    logic [3:0]            opc_q, opc_d;
    logic [DATA_W-1:0]     opnd_q, opnd_d;
    logic [DATA_W-1:0]     acc_q, acc_d;
    logic                  carry_q, carry_d;
    logic                  zero_q, zero_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;
    logic [BUSREQ_W-1:0]   bus_req_q, bus_req_d;
    logic [OPND_W-1:0]     bus_addr_q, bus_addr_d;

    logic [3:0]            instr_opc;
    logic [OPND_W-1:0]     instr_opnd;
    logic [DATA_W-1:0]     dp_acc;
    logic                  dp_carry;
    logic                  dp_zero;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
`endif

    assign instr_opc  = 4'(instr_in[OPC_W-1:0]);
    assign instr_opnd = instr_in[OPC_W +: OPND_W];

    alu_seq_datapath #(
        .DATA_W (DATA_W)
    ) u_datapath (
        .opc       (opc_q),
        .acc       (acc_q),
        .opnd      (opnd_q),
        .carry_in  (carry_q),
        .acc_nxt   (dp_acc),
        .carry_nxt (dp_carry),
        .zero_nxt  (dp_zero)
    );

    // Next-state and next-output logic; everything holds while ena is low.
    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        done_d     = done_q;
        ready_d    = ready_q;
        bus_req_d  = bus_req_q;
        bus_addr_d = bus_addr_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        opc_d  = instr_opc;
                        opnd_d = DATA_W'(instr_opnd);
`ifdef BUS_TIMEOUT_EN
                        err_d  = 1'b0;
                        cnt_d  = CNT_W'(TIMEOUT_CYC - 1);
`endif
                        if (is_reg_op(instr_opc)) begin
                            bus_addr_d = instr_opnd;
                            state_d    = BUSRD;
                        end else begin
                            state_d    = EXEC;
                        end
                    end
                end
                BUSRD: begin
                    if (bus_ack) begin
                        opnd_d  = bus_rdata;
                        state_d = EXEC;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (cnt_q == '0) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                    end
`endif
                end
                EXEC: begin
                    acc_d   = dp_acc;
                    carry_d = dp_carry;
                    zero_d  = is_nop_op(opc_q) ? zero_q : dp_zero;
                    state_d = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            done_d    = (state_d == DONE);
            ready_d   = (state_d == IDLE);
            bus_req_d = (state_d == BUSRD) ? BUSREQ_W'(REQ_READ) : BUSREQ_W'(REQ_IDLE);
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            opc_q      <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            bus_req_q  <= BUSREQ_W'(REQ_IDLE);
            bus_addr_q <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            bus_req_q  <= bus_req_d;
            bus_addr_q <= bus_addr_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign instr_ready = ready_q;
    assign bus_req     = bus_req_q;
    assign bus_addr    = bus_addr_q;
    assign acc         = acc_q;
    assign carry       = carry_q;
    assign zero        = zero_q;
    assign done        = done_q;
`ifdef BUS_TIMEOUT_EN
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: table-driven vectors with a scoreboard queue, plus hand
// sequences for enable stall, mid-op reset and bus-ack timeout.
`timescale 1ns/1ps
module tb_alu_seq_core;

    logic       clk = 1'b0;
    logic       rst, ena, instr_valid, bus_ack;
    logic [7:0] instr_in, bus_rdata, acc;
    logic       instr_ready, carry, zero, done, err;
    logic [3:0] bus_req, bus_addr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] acc;
        logic       carry;
        logic       zero;
    } exp_t;

    typedef struct {
        logic [7:0] instr;
        logic [7:0] rdata;
        int         ack_wait;
        logic [7:0] acc;
        logic       carry;
        logic       zero;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_seq_core #(
        .DATA_W      (8),
        .OPND_W      (4),
        .OPC_W       (4),
        .BUSREQ_W    (4),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .acc         (acc),
        .carry       (carry),
        .zero        (zero),
        .done        (done),
        .err         (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Called at the negedge right after the accept (imm) or ack (reg) edge.
    task automatic wait_done(input string tag);
        exp_t e;
        chk({tag, " exec done"}, done, 0);
        chk({tag, " exec bus_req"}, bus_req, 4'b0000);
        @(negedge clk);
        chk({tag, " done"}, done, 1);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue, want an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " acc"}, acc, e.acc);
            chk({tag, " carry"}, carry, e.carry);
            chk({tag, " zero"}, zero, e.zero);
        end
        @(negedge clk);
        chk({tag, " done drop"}, done, 0);
        chk({tag, " ready"}, instr_ready, 1);
    endtask

    task automatic do_instr(input vec_t v, input string tag);
        logic [3:0] opc;
        opc = v.instr[3:0];
        chk({tag, " ready in"}, instr_ready, 1);
        sb.push_back('{v.acc, v.carry, v.zero});
        instr_in    = v.instr;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        if (opc >= 4'h8 && opc <= 4'hD) begin
            for (int i = 0; i <= v.ack_wait; i++) begin
                chk({tag, " bus_req"}, bus_req, 4'b0001);
                chk({tag, " bus_addr"}, bus_addr, v.instr[7:4]);
                chk({tag, " busy ready"}, instr_ready, 0);
                if (i == v.ack_wait) begin
                    bus_ack   = 1'b1;
                    bus_rdata = v.rdata;
                end
                @(negedge clk);
            end
            bus_ack   = 1'b0;
            bus_rdata = 8'h00;
        end
        wait_done(tag);
    endtask

    task automatic accept(input logic [7:0] ins);
        instr_in    = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                instr  rdata  wait  acc   c  z
        vecs.push_back('{8'h46, 8'h00, 0, 8'h04, 0, 0}); // LDI 4
        vecs.push_back('{8'h21, 8'h00, 0, 8'h06, 0, 0}); // ADDI 2
        vecs.push_back('{8'h18, 8'h04, 3, 8'h0A, 0, 0}); // ADD R1
        vecs.push_back('{8'h26, 8'h00, 0, 8'h02, 0, 0}); // LDI 2
        vecs.push_back('{8'h32, 8'h00, 0, 8'hFF, 1, 0}); // SUBI 3 borrow
        vecs.push_back('{8'h00, 8'h00, 0, 8'hFF, 1, 0}); // NOP keeps carry
        vecs.push_back('{8'h07, 8'h00, 0, 8'hFF, 1, 0}); // illegal = NOP
        vecs.push_back('{8'h56, 8'h00, 0, 8'h05, 0, 0}); // LDI 5
        vecs.push_back('{8'h55, 8'h00, 0, 8'h00, 0, 1}); // XORI 5
        vecs.push_back('{8'h00, 8'h00, 0, 8'h00, 0, 1}); // NOP keeps zero
        vecs.push_back('{8'hF1, 8'h00, 0, 8'h0F, 0, 0}); // ADDI 15
        vecs.push_back('{8'h28, 8'hF5, 0, 8'h04, 1, 0}); // ADD R2 carry
        vecs.push_back('{8'h39, 8'h05, 1, 8'hFF, 1, 0}); // SUB R3 borrow
        vecs.push_back('{8'h4A, 8'h3C, 2, 8'h3C, 0, 0}); // AND R4
        vecs.push_back('{8'h5B, 8'h81, 0, 8'hBD, 0, 0}); // OR R5
        vecs.push_back('{8'h6C, 8'hBD, 1, 8'h00, 0, 1}); // XOR R6
        vecs.push_back('{8'h7D, 8'h81, 0, 8'h81, 0, 0}); // LDR R7
        vecs.push_back('{8'h3E, 8'h00, 0, 8'h08, 0, 0}); // SHL 3
        vecs.push_back('{8'h2F, 8'h00, 0, 8'h02, 0, 0}); // SHR 2
        vecs.push_back('{8'hF4, 8'h00, 0, 8'h0F, 0, 0}); // ORI 15
        vecs.push_back('{8'h03, 8'h00, 0, 8'h00, 0, 1}); // ANDI 0
        vecs.push_back('{8'h11, 8'h00, 0, 8'h01, 0, 0}); // ADDI 1
        vecs.push_back('{8'h12, 8'h00, 0, 8'h00, 0, 1}); // SUBI 1, equal: no borrow
        vecs.push_back('{8'h86, 8'h00, 0, 8'h08, 0, 0}); // LDI 8
        vecs.push_back('{8'h9F, 8'h00, 0, 8'h04, 0, 0}); // SHR 9 -> by 1
        vecs.push_back('{8'hF6, 8'h00, 0, 8'h0F, 0, 0}); // LDI 15
        vecs.push_back('{8'h08, 8'hF1, 0, 8'h00, 1, 1}); // ADD R0 wraps to 0
        vecs.push_back('{8'h00, 8'h00, 0, 8'h00, 1, 1}); // NOP keeps both

        rst = 1'b1; ena = 1'b1; instr_valid = 1'b0; instr_in = 8'h00;
        bus_ack = 1'b0; bus_rdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset acc", acc, 8'h00);
        chk("reset carry", carry, 0);
        chk("reset zero", zero, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset bus_req", bus_req, 4'b0000);
        chk("reset bus_addr", bus_addr, 4'h0);
        chk("reset ready", instr_ready, 1);

        foreach (vecs[i]) do_instr(vecs[i], $sformatf("vec%0d", i));

        // ena low during BUSRD, with an ack in the first stalled cycle.
        do_instr('{8'h36, 8'h00, 0, 8'h03, 0, 0}, "ena pre");
        sb.push_back('{8'h09, 1'b0, 1'b0});
        accept(8'h2D);
        chk("ena bus_req", bus_req, 4'b0001);
        chk("ena bus_addr", bus_addr, 4'h2);
        ena = 1'b0; bus_ack = 1'b1; bus_rdata = 8'h55;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 8'h00;
        for (int i = 0; i < 3; i++) begin
            chk("ena hold bus_req", bus_req, 4'b0001);
            chk("ena hold done", done, 0);
            chk("ena hold acc", acc, 8'h03);
            @(negedge clk);
        end
        ena = 1'b1;
        @(negedge clk);
        chk("ena resume bus_req", bus_req, 4'b0001);
        chk("ena resume done", done, 0);
        bus_ack = 1'b1; bus_rdata = 8'h09;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 8'h00;
        wait_done("ena ldr");

        // Reset while in BUSRD with an ack pending.
        do_instr('{8'h76, 8'h00, 0, 8'h07, 0, 0}, "rst pre");
        accept(8'h18);
        @(negedge clk);
        chk("rst busrd bus_req", bus_req, 4'b0001);
        rst = 1'b1; bus_ack = 1'b1; bus_rdata = 8'hAA;
        @(negedge clk);
        rst = 1'b0; bus_ack = 1'b0; bus_rdata = 8'h00;
        chk("rst acc", acc, 8'h00);
        chk("rst bus_req", bus_req, 4'b0000);
        chk("rst ready", instr_ready, 1);
        chk("rst done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst after done", done, 0);
            chk("rst after acc", acc, 8'h00);
        end

        // Bus-ack timeout behaviour.
        do_instr('{8'h56, 8'h00, 0, 8'h05, 0, 0}, "to pre");
`ifdef BUS_TIMEOUT_EN
        begin
            int n;
            accept(8'h38);
            n = 0;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("timeout latency", n, 15);
            chk("timeout done", done, 1);
            chk("timeout err", err, 1);
            chk("timeout acc", acc, 8'h05);
            chk("timeout carry", carry, 0);
            @(negedge clk);
            chk("timeout done drop", done, 0);
            chk("timeout err sticky", err, 1);
            chk("timeout ready", instr_ready, 1);
            sb.push_back('{8'h06, 1'b0, 1'b0});
            accept(8'h11);
            chk("timeout err clear", err, 0);
            wait_done("timeout addi");
        end
`else
        accept(8'h38);
        repeat (100) @(negedge clk);
        chk("no-timeout bus_req", bus_req, 4'b0001);
        chk("no-timeout bus_addr", bus_addr, 4'h3);
        chk("no-timeout err", err, 0);
        chk("no-timeout done", done, 0);
        sb.push_back('{8'h06, 1'b0, 1'b0});
        bus_ack = 1'b1; bus_rdata = 8'h01;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 8'h00;
        wait_done("no-timeout add");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
Parametrised sequential accumulator ALU. It is the next generation of the single-ADDI tile core: configurable data width, a full immediate/register opcode set, carry and zero flags, and a valid/ready instruction handshake. Register-form operands are fetched over a bus-request handshake with an explicit ack, replacing fixed timing. It sits between the tile I/O wrapper (instruction nibbles in, result and done out) and the external register block.

Parameters:
DATA_W, 8, accumulator, bus data and result width (min 4).
OPND_W, 4, instruction operand field width: immediate or register index.
OPC_W, 4, opcode field width; the encoding below requires 4.
BUSREQ_W, 4, bus request code width.
TIMEOUT_CYC, 15, bus-ack timeout in cycles; used only with BUS_TIMEOUT_EN.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous active-high reset.
ena  in  1  global enable; when low, all state and outputs hold.
instr_in  in  OPND_W+OPC_W  instruction: [OPC_W-1:0] opcode, upper OPND_W bits operand.
instr_valid  in  1  instruction offered.
instr_ready  out  1  core can accept an instruction.
bus_req  out  BUSREQ_W  request code: REQ_IDLE=4'b0000, REQ_READ=4'b0001.
bus_addr  out  OPND_W  register index, valid while bus_req=REQ_READ.
bus_ack  in  1  register block: bus_rdata is valid this cycle.
bus_rdata  in  DATA_W  register value.
acc  out  DATA_W  accumulator, i.e. the result.
carry  out  1  carry out of ADD, or borrow out of SUB.
zero  out  1  accumulator is zero after the last op.
done  out  1  one-cycle completion strobe.
err  out  1  sticky bus-timeout error; cleared on next accept.

Behaviour:
- Reset values: state=IDLE, acc=0, carry=0, zero=0, done=0, err=0, bus_req=REQ_IDLE, bus_addr=0, instr_ready=1 (once rst is low).
- The FSM has four states: IDLE, BUSRD, EXEC, DONE.
- ena=0: no state, counter or register update. A bus_ack arriving in that cycle is ignored.
- IDLE: instr_ready=1. Accept on instr_valid=1 and ena=1 by latching opcode and operand, and clear err.
  - Register-form opcodes go to BUSRD.
  - All other opcodes go to EXEC.
- BUSRD: bus_req=REQ_READ and bus_addr=operand, held stable until ack. On bus_ack=1, capture bus_rdata and go to EXEC.
- EXEC: update acc and flags, then go to DONE. bus_req returns to REQ_IDLE.
- DONE: done=1 for exactly one enabled cycle, then go to IDLE. instr_ready=0 in every state except IDLE.
- Latency:
  - Immediate ops: done rises 2 enabled cycles after the accept edge.
  - Register ops: done rises 2 enabled cycles after the ack edge.
  - acc is valid when done=1 and holds until the next EXEC.
- Opcodes (imm = operand zero-extended to DATA_W, R = fetched value):
  - 0 NOP; 1 ADDI; 2 SUBI; 3 ANDI; 4 ORI; 5 XORI; 6 LDI (acc=imm).
  - 7 is illegal and executes as NOP.
  - 8 ADD R; 9 SUB R; A AND R; B OR R; C XOR R; D LDR (acc=R).
  - E SHL by imm[2:0]; F SHR (logical) by imm[2:0].
  - Register-form set: 8 to D.
- Arithmetic and flags:
  - All arithmetic is modulo 2^DATA_W.
  - carry = bit DATA_W of the (DATA_W+1)-bit add. For subtract it is the borrow: 1 when acc < operand.
  - Logic, load and shift ops clear carry. NOP keeps carry.
  - zero is recomputed from the new acc on every non-NOP op.
- instr_valid while busy is not accepted and does not need to be held by the core.
- rst mid-operation, any state: next cycle is IDLE with reset values, bus_req=REQ_IDLE. A pending ack is dropped.

Optional Feature:
BUS_TIMEOUT_EN.
- Defined: a counter runs in BUSRD. If bus_ack has not arrived by TIMEOUT_CYC enabled cycles, go to DONE with err=1, acc and flags unchanged, and done still pulsed.
- Undefined: BUSRD waits indefinitely, err is tied 0, and no counter is synthesised.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode enum and the register-form predicate function;
  - state enum {IDLE, BUSRD, EXEC, DONE};
  - BUSREQ codes REQ_IDLE and REQ_READ.
- Sub-module alu_seq_datapath: combinational op/flag unit. Inputs are opcode, acc, operand and old carry; outputs are new acc, carry and zero. The FSM stays in alu_seq_core.

Test Plan:
1. Reset, LDI 4 (0x46), then ADDI 2 (0x21) -> acc=6, carry=0, zero=0; done 2 cycles after each accept.
2. acc=6; ADD R1 (0x18); ack with rdata=4 after 3 cycles -> bus_req=0001 and bus_addr=1 stable until ack; acc=10; done 2 cycles after the ack.
3. DATA_W=8: LDI 2 then SUBI 3 -> acc=0xFF, carry=1. Then LDI 5, XORI 5 -> acc=0, zero=1, carry=0.
4. ena=0 for 4 cycles during BUSRD, with ack=1 in the first of them -> no capture, state holds. After ena returns, ack with rdata=9 on LDR R2 -> acc=9.
5. rst during BUSRD with acc=7 -> next cycle acc=0, bus_req=0000, instr_ready=1, no done.
6. BUS_TIMEOUT_EN defined, ADD R3, no ack -> done and err=1 after 15 BUSRD cycles, acc unchanged; a following ADDI 1 clears err. Macro undefined -> still in BUSRD after 100 cycles, err=0.
